// File: rtl/branch_history_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_history_ctrl_pkg
// Description : Shared configuration, checkpoint record and arbitration helper
//               for the fetch-side branch history controller.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_history_ctrl_pkg;

    localparam int c_FETCH_WIDTH          = 4;
    localparam int c_GHR_WIDTH            = 8;
    localparam int c_COMMIT_WIDTH         = 2;
    localparam int c_CHECKPOINT_ID_WIDTH  = 4;
    localparam int c_LOCAL_HISTORY_WIDTH  = 8;
    localparam int c_ARCH_REG_NUM         = 32;
    localparam int c_LSB_VEC_WIDTH        = 32;
    localparam int c_LSB_IDX_WIDTH        = $clog2(c_LSB_VEC_WIDTH);

    typedef struct packed {
        logic [c_GHR_WIDTH-1:0]           global_history;
        logic [c_LOCAL_HISTORY_WIDTH-1:0] local_history;
        logic [c_ARCH_REG_NUM-1:0]        rat_phy_map_table_valid;
        logic [c_ARCH_REG_NUM-1:0]        rat_phy_map_table_visible;
    } checkpoint_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } bhc_state_e;

    typedef struct packed {
        logic                       found;
        logic [c_LSB_IDX_WIDTH-1:0] idx;
    } lsb_sel_t;

    // Lowest-set-bit arbiter; narrower requesters zero-extend into the vector.
    function automatic lsb_sel_t lowest_set(input logic [c_LSB_VEC_WIDTH-1:0] vec);
        lsb_sel_t res;
        res = '0;
        for (int i = c_LSB_VEC_WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                res.found = 1'b1;
                res.idx   = c_LSB_IDX_WIDTH'(i);
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_history_ctrl_ghr_commit_shifter.sv
`default_nettype none
// ============================================================================
// Module      : branch_history_ctrl_ghr_commit_shifter
// Description : Applies all committing branch outcomes to a GHR in slot order.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_history_ctrl_ghr_commit_shifter #(
    parameter int GHR_WIDTH    = 8,
    parameter int COMMIT_WIDTH = 2
) (
    input  logic [GHR_WIDTH-1:0]    ghr_in,
    input  logic [COMMIT_WIDTH-1:0] branch_valid,
    input  logic [COMMIT_WIDTH-1:0] taken,
    output logic [GHR_WIDTH-1:0]    ghr_out
);

    always_comb begin
        ghr_out = ghr_in;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (branch_valid[i]) begin
                ghr_out = {ghr_out[GHR_WIDTH-2:0], taken[i]};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_history_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_history_ctrl
// Description : Serialises predicted branches of a fetch group into checkpoint
//               pushes and maintains speculative and committed global history.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_history_ctrl
    import branch_history_ctrl_pkg::*;
#(
    parameter int FETCH_WIDTH  = c_FETCH_WIDTH,
    parameter int GHR_WIDTH    = c_GHR_WIDTH,
    parameter int COMMIT_WIDTH = c_COMMIT_WIDTH,
    localparam int SLOT_W      = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             fetch_bhc_valid,
    input  logic [FETCH_WIDTH-1:0]           fetch_bhc_is_branch,
    input  logic [FETCH_WIDTH-1:0]           fetch_bhc_pred_taken,
    output logic                             bhc_fetch_ready,
    output logic [SLOT_W-1:0]                bhc_fetch_push_slot,
    output logic                             bhc_fetch_push_valid,
    output logic [c_CHECKPOINT_ID_WIDTH-1:0] bhc_fetch_cp_id,
    input  logic [c_CHECKPOINT_ID_WIDTH-1:0] cpbuf_fetch_new_id,
    input  logic                             cpbuf_fetch_new_id_valid,
    output checkpoint_t                      fetch_cpbuf_data,
    output logic                             fetch_cpbuf_push,
    input  logic                             exbru_bhc_mispredict,
    input  logic                             exbru_bhc_taken,
    input  checkpoint_t                      cpbuf_exbru_data,
    input  logic [COMMIT_WIDTH-1:0]          commit_bhc_branch_valid,
    input  logic [COMMIT_WIDTH-1:0]          commit_bhc_taken,
    input  logic                             commit_cpbuf_flush,
    output logic [GHR_WIDTH-1:0]             bhc_ghr
);

    bhc_state_e             state_q, state_d;
    logic [FETCH_WIDTH-1:0] pending_q, pending_d;
    logic [GHR_WIDTH-1:0]   spec_ghr_q, spec_ghr_d;
    logic [GHR_WIDTH-1:0]   commit_ghr_q, commit_ghr_d;

    lsb_sel_t               w_sel;
    logic [SLOT_W-1:0]      w_slot;
    logic [FETCH_WIDTH-1:0] w_work_mask;
    logic [FETCH_WIDTH-1:0] w_remaining;
    logic                   w_recover;
    logic                   w_do_push;
    logic                   w_unused_bits;

    branch_history_ctrl_ghr_commit_shifter #(
        .GHR_WIDTH    (GHR_WIDTH),
        .COMMIT_WIDTH (COMMIT_WIDTH)
    ) u_commit_shifter (
        .ghr_in       (commit_ghr_q),
        .branch_valid (commit_bhc_branch_valid),
        .taken        (commit_bhc_taken),
        .ghr_out      (commit_ghr_d)
    );

    always_comb begin
        state_d              = state_q;
        pending_d            = pending_q;
        spec_ghr_d           = spec_ghr_q;
        bhc_fetch_ready      = 1'b0;
        bhc_fetch_push_valid = 1'b0;
        fetch_cpbuf_push     = 1'b0;
        fetch_cpbuf_data     = '0;

        w_work_mask = (state_q == ST_BUSY) ? pending_q
                    : (fetch_bhc_valid ? fetch_bhc_is_branch : '0);
        w_sel       = lowest_set(c_LSB_VEC_WIDTH'(w_work_mask));
        w_slot      = w_sel.idx[SLOT_W-1:0];
        w_recover   = commit_cpbuf_flush || exbru_bhc_mispredict;
        w_do_push   = w_sel.found && cpbuf_fetch_new_id_valid && !w_recover && !rst;
        w_remaining = w_do_push ? (w_work_mask & ~(FETCH_WIDTH'(1) << w_slot)) : w_work_mask;

        bhc_fetch_push_slot = w_slot;
        bhc_fetch_cp_id     = cpbuf_fetch_new_id;
        // The checkpoint carries history as it stood before this branch.
        fetch_cpbuf_data.global_history = spec_ghr_q;

        if (commit_cpbuf_flush) begin
            spec_ghr_d = commit_ghr_d;
            pending_d  = '0;
            state_d    = ST_IDLE;
        end else if (exbru_bhc_mispredict) begin
            spec_ghr_d = {cpbuf_exbru_data.global_history[GHR_WIDTH-2:0], exbru_bhc_taken};
            pending_d  = '0;
            state_d    = ST_IDLE;
        end else begin
            pending_d = w_remaining;
            state_d   = (|w_remaining) ? ST_BUSY : ST_IDLE;
            if (w_do_push) begin
                spec_ghr_d           = {spec_ghr_q[GHR_WIDTH-2:0], fetch_bhc_pred_taken[w_slot]};
                bhc_fetch_push_valid = 1'b1;
                fetch_cpbuf_push     = 1'b1;
            end
            bhc_fetch_ready = fetch_bhc_valid && (w_remaining == '0) && !rst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            spec_ghr_q   <= '0;
            commit_ghr_q <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            spec_ghr_q   <= spec_ghr_d;
            commit_ghr_q <= commit_ghr_d;
        end
    end

    assign bhc_ghr = spec_ghr_q;

    // Readback fields other than the history are not needed for recovery.
    assign w_unused_bits = ^{w_sel.idx, cpbuf_exbru_data};

endmodule
`default_nettype wire

// File: tb/tb_branch_history_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_history_ctrl
// Description : Scoreboard bench for branch_history_ctrl with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_history_ctrl;
    import branch_history_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_bhc_valid;
    logic [3:0]  fetch_bhc_is_branch;
    logic [3:0]  fetch_bhc_pred_taken;
    logic        bhc_fetch_ready;
    logic [1:0]  bhc_fetch_push_slot;
    logic        bhc_fetch_push_valid;
    logic [3:0]  bhc_fetch_cp_id;
    logic [3:0]  cpbuf_fetch_new_id;
    logic        cpbuf_fetch_new_id_valid;
    checkpoint_t fetch_cpbuf_data;
    logic        fetch_cpbuf_push;
    logic        exbru_bhc_mispredict;
    logic        exbru_bhc_taken;
    checkpoint_t cpbuf_exbru_data;
    logic [1:0]  commit_bhc_branch_valid;
    logic [1:0]  commit_bhc_taken;
    logic        commit_cpbuf_flush;
    logic [7:0]  bhc_ghr;

    always #5 clk = ~clk;

    branch_history_ctrl dut (
        .clk                      (clk),
        .rst                      (rst),
        .fetch_bhc_valid          (fetch_bhc_valid),
        .fetch_bhc_is_branch      (fetch_bhc_is_branch),
        .fetch_bhc_pred_taken     (fetch_bhc_pred_taken),
        .bhc_fetch_ready          (bhc_fetch_ready),
        .bhc_fetch_push_slot      (bhc_fetch_push_slot),
        .bhc_fetch_push_valid     (bhc_fetch_push_valid),
        .bhc_fetch_cp_id          (bhc_fetch_cp_id),
        .cpbuf_fetch_new_id       (cpbuf_fetch_new_id),
        .cpbuf_fetch_new_id_valid (cpbuf_fetch_new_id_valid),
        .fetch_cpbuf_data         (fetch_cpbuf_data),
        .fetch_cpbuf_push         (fetch_cpbuf_push),
        .exbru_bhc_mispredict     (exbru_bhc_mispredict),
        .exbru_bhc_taken          (exbru_bhc_taken),
        .cpbuf_exbru_data         (cpbuf_exbru_data),
        .commit_bhc_branch_valid  (commit_bhc_branch_valid),
        .commit_bhc_taken         (commit_bhc_taken),
        .commit_cpbuf_flush       (commit_cpbuf_flush),
        .bhc_ghr                  (bhc_ghr)
    );

    typedef struct packed {
        logic       push;
        logic [1:0] slot;
        logic [3:0] id;
        logic [7:0] gh;
        logic       ready;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] ghr_exp_q[$];
    logic       chk_ghr;
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: consumes one expectation whenever the DUT pushes or signals ready.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            chk("rst_strobes", {30'd0, bhc_fetch_push_valid, fetch_cpbuf_push}, 32'd0);
            chk("rst_ready", {31'd0, bhc_fetch_ready}, 32'd0);
        end else begin
            if (bhc_fetch_push_valid || fetch_cpbuf_push || bhc_fetch_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: push=%0d ready=%0d slot=%0d, expected no output",
                             bhc_fetch_push_valid, bhc_fetch_ready, bhc_fetch_push_slot);
                end else begin
                    e = exp_q.pop_front();
                    chk("push_valid", {31'd0, bhc_fetch_push_valid}, {31'd0, e.push});
                    chk("push_strobe", {31'd0, fetch_cpbuf_push}, {31'd0, e.push});
                    chk("ready", {31'd0, bhc_fetch_ready}, {31'd0, e.ready});
                    if (e.push) begin
                        chk("push_slot", {30'd0, bhc_fetch_push_slot}, {30'd0, e.slot});
                        chk("cp_id", {28'd0, bhc_fetch_cp_id}, {28'd0, e.id});
                        chk("cp_global_history", {24'd0, fetch_cpbuf_data.global_history}, {24'd0, e.gh});
                        chk("cp_local_history", {24'd0, fetch_cpbuf_data.local_history}, 32'd0);
                        chk("cp_rat_valid", fetch_cpbuf_data.rat_phy_map_table_valid, 32'd0);
                    end
                end
            end
            if (chk_ghr) begin
                if (ghr_exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL ghr_queue: got 0x%0h, expected an entry to compare", bhc_ghr);
                end else begin
                    chk("spec_ghr", {24'd0, bhc_ghr}, {24'd0, ghr_exp_q.pop_front()});
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_push(input logic [1:0] slot, input logic [3:0] id,
                            input logic [7:0] gh, input logic ready);
        exp_t e;
        e = '{push: 1'b1, slot: slot, id: id, gh: gh, ready: ready};
        exp_q.push_back(e);
    endtask

    task automatic exp_ready();
        exp_t e;
        e = '{push: 1'b0, slot: 2'd0, id: 4'd0, gh: 8'd0, ready: 1'b1};
        exp_q.push_back(e);
    endtask

    task automatic exp_ghr(input logic [7:0] v);
        chk_ghr = 1'b1;
        ghr_exp_q.push_back(v);
    endtask

    initial begin
        rst = 1'b1;
        chk_ghr = 1'b0;
        fetch_bhc_valid = 1'b0;
        fetch_bhc_is_branch = '0;
        fetch_bhc_pred_taken = '0;
        cpbuf_fetch_new_id = '0;
        cpbuf_fetch_new_id_valid = 1'b1;
        exbru_bhc_mispredict = 1'b0;
        exbru_bhc_taken = 1'b0;
        cpbuf_exbru_data = '0;
        commit_bhc_branch_valid = '0;
        commit_bhc_taken = '0;
        commit_cpbuf_flush = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;

        // Branch-free group is ready immediately.
        fetch_bhc_valid = 1'b1; fetch_bhc_is_branch = 4'b0000;
        exp_ready(); exp_ghr(8'h00); cyc(); chk_ghr = 1'b0;

        // Two-branch group serialised over two cycles.
        fetch_bhc_is_branch = 4'b0101; fetch_bhc_pred_taken = 4'b0001;
        cpbuf_fetch_new_id = 4'd3; exp_push(2'd0, 4'd3, 8'h00, 1'b0); cyc();
        cpbuf_fetch_new_id = 4'd4; exp_push(2'd2, 4'd4, 8'h01, 1'b1); cyc();
        fetch_bhc_valid = 1'b0; exp_ghr(8'h02); cyc(); chk_ghr = 1'b0;

        // Buffer full for three cycles, then the same group proceeds.
        fetch_bhc_valid = 1'b1; cpbuf_fetch_new_id_valid = 1'b0;
        repeat (3) cyc();
        cpbuf_fetch_new_id_valid = 1'b1;
        cpbuf_fetch_new_id = 4'd5; exp_push(2'd0, 4'd5, 8'h02, 1'b0); cyc();
        cpbuf_fetch_new_id = 4'd6; exp_push(2'd2, 4'd6, 8'h05, 1'b1); cyc();
        fetch_bhc_valid = 1'b0; exp_ghr(8'h0A); cyc(); chk_ghr = 1'b0;

        // Mispredict while BUSY: no push, history rebuilt from the readback.
        fetch_bhc_valid = 1'b1;
        cpbuf_fetch_new_id = 4'd7; exp_push(2'd0, 4'd7, 8'h0A, 1'b0); cyc();
        exbru_bhc_mispredict = 1'b1; exbru_bhc_taken = 1'b1;
        cpbuf_exbru_data.global_history = 8'h05; cyc();
        exbru_bhc_mispredict = 1'b0;
        fetch_bhc_is_branch = 4'b0001; fetch_bhc_pred_taken = 4'b0000;
        cpbuf_fetch_new_id = 4'd8; exp_push(2'd0, 4'd8, 8'h0B, 1'b1); exp_ghr(8'h0B); cyc();
        fetch_bhc_valid = 1'b0; exp_ghr(8'h16); cyc(); chk_ghr = 1'b0;

        // Commits in slot order, then a flush in the same cycle as more commits.
        commit_bhc_branch_valid = 2'b01; commit_bhc_taken = 2'b01; cyc();
        commit_bhc_branch_valid = 2'b11; commit_bhc_taken = 2'b01; commit_cpbuf_flush = 1'b1;
        fetch_bhc_valid = 1'b1; fetch_bhc_is_branch = 4'b0001; fetch_bhc_pred_taken = 4'b0001;
        cpbuf_fetch_new_id = 4'd9; cyc();
        commit_bhc_branch_valid = 2'b00; commit_bhc_taken = 2'b00; commit_cpbuf_flush = 1'b0;
        fetch_bhc_valid = 1'b0; exp_ghr(8'h06); cyc(); chk_ghr = 1'b0;

        // Flush outranks a simultaneous mispredict.
        fetch_bhc_valid = 1'b1; cpbuf_fetch_new_id = 4'd10;
        exp_push(2'd0, 4'd10, 8'h06, 1'b1); cyc();
        fetch_bhc_valid = 1'b0; commit_cpbuf_flush = 1'b1; exbru_bhc_mispredict = 1'b1;
        exbru_bhc_taken = 1'b1; cpbuf_exbru_data.global_history = 8'h33; cyc();
        commit_cpbuf_flush = 1'b0; exbru_bhc_mispredict = 1'b0;
        exp_ghr(8'h06); cyc(); chk_ghr = 1'b0;

        // Reset while BUSY clears history, pending work and the committed GHR.
        fetch_bhc_valid = 1'b1; fetch_bhc_is_branch = 4'b0011; fetch_bhc_pred_taken = 4'b0011;
        cpbuf_fetch_new_id = 4'd11; exp_push(2'd0, 4'd11, 8'h06, 1'b0); cyc();
        rst = 1'b1; cyc();
        rst = 1'b0; fetch_bhc_is_branch = 4'b0000; fetch_bhc_pred_taken = 4'b0000;
        exp_ready(); exp_ghr(8'h00); cyc(); chk_ghr = 1'b0;
        fetch_bhc_is_branch = 4'b0001; fetch_bhc_pred_taken = 4'b0001;
        cpbuf_fetch_new_id = 4'd12; exp_push(2'd0, 4'd12, 8'h00, 1'b1); cyc();
        fetch_bhc_valid = 1'b0; commit_cpbuf_flush = 1'b1; cyc();
        commit_cpbuf_flush = 1'b0; exp_ghr(8'h00); cyc(); chk_ghr = 1'b0;

        repeat (2) cyc();
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL missing_output: got none, expected push=%0d slot=%0d ready=%0d",
                     e.push, e.slot, e.ready);
        end
        while (ghr_exp_q.size() > 0) begin
            logic [7:0] g;
            g = ghr_exp_q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL missing_ghr_check: got none, expected 0x%0h", g);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
